// File: rtl/matrix_fetch_pkg.sv
// Shared types and constants for the matrix row fetch path (BRAM wrapper,
// fetch controller and downstream matrix buffer).
package matrix_fetch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_DATA,
      PRESENT,
      DONE
   } fetch_state_e;

   localparam int ROW_IDX_W   = 4;
   localparam int MF_NUM_ROWS = 8;
   localparam int MF_DATA_W   = 64;

endpackage

// File: rtl/matrix_fetch_ctrl.sv
// Fetches NUM_ROWS consecutive matrix rows over Avalon-MM, one read in flight,
// and streams each row out on a valid/ready port. Optional watchdog: FETCH_TIMEOUT_EN.
module matrix_fetch_ctrl
   import matrix_fetch_pkg::*;
#(
   parameter int                NUM_ROWS    = MF_NUM_ROWS,
   parameter int                DATA_W      = MF_DATA_W,
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int                TIMEOUT_CYC = 64
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [ADDR_W-1:0]    avm_address,
   output logic                 avm_read,
   input  logic [DATA_W-1:0]    avm_readdata,
   input  logic                 avm_readdatavalid,
   input  logic                 avm_waitrequest,
   output logic [DATA_W-1:0]    row_data,
   output logic [ROW_IDX_W-1:0] row_idx,
   output logic                 row_valid,
   input  logic                 row_ready
);

   if (NUM_ROWS < 1 || NUM_ROWS > 16 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("matrix_fetch_ctrl: NUM_ROWS must be 1..16 and TIMEOUT_CYC >= 1");
   end

   fetch_state_e          state_q, state_d;
   logic [ROW_IDX_W-1:0]  row_q, row_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [ADDR_W-1:0]     avm_address_q, avm_address_d;
   logic                  avm_read_q, avm_read_d;
   logic [DATA_W-1:0]     row_data_q, row_data_d;
   logic [ROW_IDX_W-1:0]  row_idx_q, row_idx_d;
   logic                  row_valid_q, row_valid_d;

`ifdef FETCH_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             error_q, error_d;
`endif

   always_comb begin
      state_d       = state_q;
      row_d         = row_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      avm_address_d = avm_address_q;
      avm_read_d    = 1'b0;
      row_data_d    = row_data_q;
      row_idx_d     = row_idx_q;
      row_valid_d   = row_valid_q;
`ifdef FETCH_TIMEOUT_EN
      tmo_d         = tmo_q;
      error_d       = error_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               busy_d  = 1'b1;
               row_d   = '0;
               state_d = ISSUE;
`ifdef FETCH_TIMEOUT_EN
               error_d = 1'b0;
`endif
            end
         end
         ISSUE: begin
            // Leaving ISSUE in the same cycle the request is launched keeps
            // the read strobe to a single cycle whatever waitrequest does next.
            if (!avm_waitrequest) begin
               avm_read_d    = 1'b1;
               avm_address_d = BASE_ADDR + ADDR_W'(row_q);
               state_d       = WAIT_DATA;
`ifdef FETCH_TIMEOUT_EN
               tmo_d         = '0;
`endif
            end
         end
         WAIT_DATA: begin
            if (avm_readdatavalid) begin
               row_data_d  = avm_readdata;
               row_idx_d   = row_q;
               row_valid_d = 1'b1;
               state_d     = PRESENT;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
               error_d = 1'b1;
               state_d = DONE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
         end
         PRESENT: begin
            if (row_ready) begin
               row_valid_d = 1'b0;
               if (row_q == ROW_IDX_W'(NUM_ROWS - 1)) begin
                  state_d = DONE;
               end else begin
                  row_d   = row_q + 1'b1;
                  state_d = ISSUE;
               end
            end
         end
         DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         row_q         <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         avm_address_q <= '0;
         avm_read_q    <= 1'b0;
         row_data_q    <= '0;
         row_idx_q     <= '0;
         row_valid_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         tmo_q         <= '0;
         error_q       <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         row_q         <= row_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         avm_address_q <= avm_address_d;
         avm_read_q    <= avm_read_d;
         row_data_q    <= row_data_d;
         row_idx_q     <= row_idx_d;
         row_valid_q   <= row_valid_d;
`ifdef FETCH_TIMEOUT_EN
         tmo_q         <= tmo_d;
         error_q       <= error_d;
`endif
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign avm_address = avm_address_q;
   assign avm_read    = avm_read_q;
   assign row_data    = row_data_q;
   assign row_idx     = row_idx_q;
   assign row_valid   = row_valid_q;
`ifdef FETCH_TIMEOUT_EN
   assign error       = error_q;
`else
   assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_fetch_ctrl.sv
// Scoreboard bench for matrix_fetch_ctrl with a fixed-latency Avalon slave model.
module tb_matrix_fetch_ctrl;

   localparam int NR  = 8;
   localparam int DW  = 64;
   localparam int AW  = 32;
   localparam int LAT = 13;
   localparam int TMO = 64;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          busy, done, error;
   logic [AW-1:0] avm_address;
   logic          avm_read;
   logic [DW-1:0] avm_readdata;
   logic          avm_readdatavalid;
   logic          avm_waitrequest = 1'b0;
   logic [DW-1:0] row_data;
   logic [3:0]    row_idx;
   logic          row_valid;
   logic          row_ready = 1'b0;

   typedef struct packed {
      logic [3:0]    idx;
      logic [DW-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   rd_cnt   = 0;
   int   hs_cnt   = 0;
   int   done_cnt = 0;
   bit   prev_read = 1'b0;
   bit   inj_req   = 1'b0;
   int   silent_row = -1;

   matrix_fetch_ctrl #(
      .NUM_ROWS(NR), .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(32'h0), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
      .error(error), .avm_address(avm_address), .avm_read(avm_read),
      .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
      .avm_waitrequest(avm_waitrequest), .row_data(row_data), .row_idx(row_idx),
      .row_valid(row_valid), .row_ready(row_ready)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [DW-1:0] row_word(input int k);
      logic [7:0] b;
      b = 8'(k + 1);
      return {8{b}};
   endfunction

   task automatic push_rows(input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.idx  = 4'(k);
         e.data = row_word(k);
         exp_q.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int max, output bit seen, output int cyc);
      seen = 1'b0;
      cyc  = 0;
      for (int i = 0; i < max && !seen; i++) begin
         tick();
         cyc++;
         if (done) seen = 1'b1;
      end
   endtask

   // Slave: accepts a read when waitrequest is low, answers LAT cycles later
   initial begin : slave
      bit pend;
      int lat;
      int k;
      pend = 1'b0; lat = 0; k = 0;
      avm_readdatavalid = 1'b0;
      avm_readdata = '0;
      forever begin
         @(posedge clk);
         #2;
         avm_readdatavalid = 1'b0;
         if (pend) begin
            if (lat <= 1) begin
               avm_readdatavalid = 1'b1;
               avm_readdata = row_word(k);
               pend = 1'b0;
            end else lat--;
         end
         if (inj_req) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = 64'hDEAD_BEEF_CAFE_F00D;
            inj_req = 1'b0;
         end
         if (avm_read && !avm_waitrequest && int'(avm_address) != silent_row) begin
            pend = 1'b1;
            lat  = LAT;
            k    = int'(avm_address);
         end
      end
   end

   // Monitor: read strobe shape/address, row handshakes against the scoreboard, done/busy
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (avm_read) begin
            n_checks++;
            if (prev_read) begin
               n_fail++;
               $display("FAIL read_pulse: avm_read high 2 cycles, required 1");
            end
            n_checks++;
            if (avm_address !== AW'(rd_cnt)) begin
               n_fail++;
               $display("FAIL read_addr: got %0d required %0d", avm_address, rd_cnt);
            end
            rd_cnt++;
         end
         prev_read = avm_read;
         if (row_valid && row_ready) begin
            hs_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL row_extra: idx %0d data %h, none expected", row_idx, row_data);
            end else begin
               e = exp_q.pop_front();
               if (row_idx !== e.idx || row_data !== e.data) begin
                  n_fail++;
                  $display("FAIL row_data: got idx %0d data %h required idx %0d data %h",
                           row_idx, row_data, e.idx, e.data);
               end
            end
         end
         if (done) begin
            done_cnt++;
            n_checks++;
            if (busy) begin
               n_fail++;
               $display("FAIL done_busy: busy=%b with done, required 0", busy);
            end
         end
      end
   end

   task automatic test_reset();
      tick();
      tick();
      n_checks++;
      if ({busy, done, error, avm_read, row_valid, row_idx} !== 9'd0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b required 0", {busy, done, error, avm_read, row_valid, row_idx});
      end
      n_checks++;
      if (avm_address !== '0 || row_data !== '0) begin
         n_fail++;
         $display("FAIL reset_data: addr %h data %h required 0", avm_address, row_data);
      end
      reset_n = 1'b1;
      tick();
      tick();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: busy %b required 0", busy);
      end
   endtask

   task automatic test_basic();
      bit seen;
      int cyc, hs0, d0;
      rd_cnt = 0; hs0 = hs_cnt; d0 = done_cnt;
      push_rows(NR);
      row_ready = 1'b1;
      pulse_start();
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_busy: got %b required 1", busy);
      end
      wait_done(1000, seen, cyc);
      n_checks++;
      if (!seen || cyc + 1 != NR * (LAT + 3) + 2) begin
         n_fail++;
         $display("FAIL basic_time: done seen %b after %0d cycles required %0d", seen, cyc + 1, NR * (LAT + 3) + 2);
      end
      tick();
      n_checks++;
      if (rd_cnt != NR || hs_cnt - hs0 != NR || exp_q.size() != 0 || done_cnt - d0 != 1) begin
         n_fail++;
         $display("FAIL basic_counts: reads %0d rows %0d left %0d dones %0d required %0d %0d 0 1",
                  rd_cnt, hs_cnt - hs0, exp_q.size(), done_cnt - d0, NR, NR);
      end
      n_checks++;
      if (busy !== 1'b0 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_end: busy %b error %b required 0 0", busy, error);
      end
   endtask

   task automatic test_stall();
      bit seen;
      int stall, hs0;
      rd_cnt = 0; hs0 = hs_cnt; stall = 0; seen = 1'b0;
      push_rows(NR);
      row_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 1000 && !seen; i++) begin
         tick();
         if (done) seen = 1'b1;
         if (row_valid && row_idx == 4'd3 && stall < 20) begin
            row_ready = 1'b0;
            stall++;
            if (stall == 20) begin
               n_checks++;
               if (row_data !== row_word(3) || rd_cnt != 4) begin
                  n_fail++;
                  $display("FAIL stall_hold: data %h reads %0d required %h 4", row_data, rd_cnt, row_word(3));
               end
            end
         end else row_ready = 1'b1;
      end
      tick();
      n_checks++;
      if (!seen || stall != 20 || rd_cnt != NR || hs_cnt - hs0 != NR || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL stall_end: done %b stall %0d reads %0d rows %0d left %0d", seen, stall, rd_cnt, hs_cnt - hs0, exp_q.size());
      end
   endtask

   task automatic test_waitreq();
      bit seen;
      int cyc, hs0;
      rd_cnt = 0; hs0 = hs_cnt;
      push_rows(NR);
      row_ready = 1'b1;
      avm_waitrequest = 1'b1;
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (avm_read !== 1'b0) begin
            n_fail++;
            $display("FAIL waitreq_read: cycle %0d avm_read %b required 0", i, avm_read);
         end
      end
      avm_waitrequest = 1'b0;
      wait_done(1000, seen, cyc);
      tick();
      n_checks++;
      if (!seen || rd_cnt != NR || hs_cnt - hs0 != NR || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL waitreq_end: done %b reads %0d rows %0d left %0d required 1 %0d %0d 0",
                  seen, rd_cnt, hs_cnt - hs0, exp_q.size(), NR, NR);
      end
   endtask

   task automatic test_ignore();
      bit seen, sent_busy, sent_done, last_hs;
      int ph, hold, hs0;
      rd_cnt = 0; hs0 = hs_cnt; ph = 0; hold = 0;
      seen = 1'b0; sent_busy = 1'b0; sent_done = 1'b0; last_hs = 1'b0;
      push_rows(NR);
      row_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 1000 && !seen; i++) begin
         tick();
         start = 1'b0;
         if (done) seen = 1'b1;
         if (rd_cnt == 5 && !sent_busy) begin
            start = 1'b1;
            sent_busy = 1'b1;
         end
         if (ph == 0 && row_valid && row_idx == 4'd2) begin
            row_ready = 1'b0;
            inj_req = 1'b1;
            ph = 1;
         end else if (ph == 1) begin
            hold++;
            if (hold == 3) begin
               n_checks++;
               if (row_data !== row_word(2) || row_idx !== 4'd2 || row_valid !== 1'b1) begin
                  n_fail++;
                  $display("FAIL spurious_rdv: data %h idx %0d valid %b required %h 2 1",
                           row_data, row_idx, row_valid, row_word(2));
               end
               row_ready = 1'b1;
               ph = 2;
            end
         end
         if (last_hs && !sent_done) begin
            start = 1'b1;
            sent_done = 1'b1;
         end
         last_hs = row_valid && row_ready && row_idx == 4'd7;
      end
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      n_checks++;
      if (busy !== 1'b0 || rd_cnt != NR) begin
         n_fail++;
         $display("FAIL start_in_done: busy %b reads %0d required 0 %0d", busy, rd_cnt, NR);
      end
      n_checks++;
      if (!seen || !sent_busy || !sent_done || ph != 2 || hs_cnt - hs0 != NR || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL ignore_end: done %b starts %b%b phase %0d rows %0d left %0d",
                  seen, sent_busy, sent_done, ph, hs_cnt - hs0, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      bit seen, anyv;
      int cyc, hs0;
      rd_cnt = 0; seen = 1'b0; anyv = 1'b0;
      push_rows(NR);
      row_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 200 && rd_cnt < 3; i++) tick();
      n_checks++;
      if (rd_cnt != 3) begin
         n_fail++;
         $display("FAIL midrst_reach: reads %0d required 3", rd_cnt);
      end
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, error, avm_read, row_valid, row_idx} !== 9'd0 || avm_address !== '0 || row_data !== '0) begin
         n_fail++;
         $display("FAIL midrst_outs: ctrl %b addr %h data %h required all 0",
                  {busy, done, error, avm_read, row_valid, row_idx}, avm_address, row_data);
      end
      exp_q.delete();
      tick();
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (row_valid || busy) anyv = 1'b1;
      end
      n_checks++;
      if (anyv) begin
         n_fail++;
         $display("FAIL late_rdv: row_valid/busy rose after reset, required 0");
      end
      rd_cnt = 0; hs0 = hs_cnt;
      push_rows(NR);
      pulse_start();
      wait_done(1000, seen, cyc);
      tick();
      n_checks++;
      if (!seen || rd_cnt != NR || hs_cnt - hs0 != NR || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL midrst_refetch: done %b reads %0d rows %0d left %0d", seen, rd_cnt, hs_cnt - hs0, exp_q.size());
      end
   endtask

`ifdef FETCH_TIMEOUT_EN
   task automatic test_timeout();
      bit seen, bad;
      int t5, td, cyc, hs0;
      rd_cnt = 0; hs0 = hs_cnt; seen = 1'b0; bad = 1'b0; t5 = -1; td = -1;
      silent_row = 5;
      push_rows(5);
      row_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 1000 && !seen; i++) begin
         tick();
         if (rd_cnt == 6 && t5 < 0) t5 = i;
         if (row_valid && row_idx == 4'd5) bad = 1'b1;
         if (done) begin
            seen = 1'b1;
            td = i;
         end
      end
      tick();
      n_checks++;
      if (!seen || t5 < 0 || td - t5 < TMO || td - t5 > TMO + 1) begin
         n_fail++;
         $display("FAIL tmo_time: done %b after %0d cycles required %0d", seen, td - t5, TMO);
      end
      n_checks++;
      if (error !== 1'b1 || busy !== 1'b0 || bad || hs_cnt - hs0 != 5 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL tmo_state: error %b busy %b row5 %b rows %0d left %0d required 1 0 0 5 0",
                  error, busy, bad, hs_cnt - hs0, exp_q.size());
      end
      silent_row = -1;
      rd_cnt = 0; hs0 = hs_cnt;
      push_rows(NR);
      pulse_start();
      n_checks++;
      if (error !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_clear: error %b required 0", error);
      end
      wait_done(1000, seen, cyc);
      tick();
      n_checks++;
      if (!seen || rd_cnt != NR || hs_cnt - hs0 != NR || error !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_refetch: done %b reads %0d rows %0d error %b", seen, rd_cnt, hs_cnt - hs0, error);
      end
   endtask
`endif

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      test_reset();
      test_basic();
      test_stall();
      test_waitreq();
      test_ignore();
      test_reset_mid();
`ifdef FETCH_TIMEOUT_EN
      test_timeout();
`endif
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
